// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default geometry and Gray/binary conversions.
// Conversions work on a 32-bit zero-extended value so any pointer width up
// to 32 bits can use them; callers cast the result back to their width.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 7;
    localparam int FIFO_DEPTH      = 2**FIFO_ADDR_WIDTH;

    function automatic logic [31:0] bin2gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

    // Zero upper bits stay zero, so the lower bits decode correctly
    // regardless of the caller's real pointer width.
    function automatic logic [31:0] gray2bin(input logic [31:0] x);
        logic [31:0] b;
        b[31] = x[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ x[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk, rst_n  destination clock, async active-low reset
//   d_async     Gray pointer from the source domain (no logic ahead of flop 0)
//   q_sync      synchronised pointer, STAGES destination edges later
module fifo_ptr_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] q_sync
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_async;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wrt_ctrl.sv
// Write-domain pointer/flag controller of the async FIFO.
// Ports:
//   wrt_clk, wrt_rst_n  write clock, async active-low reset
//   wrt_en              write request (shared with fifo_mem)
//   rd_ptr_gray         read Gray pointer from rd_clk domain (asynchronous)
//   ovf_clr             synchronous overflow clear
//   wrt_addr            memory write address (current binary pointer low bits)
//   wrt_ptr_gray        registered Gray write pointer for the read-side sync
//   full, almost_full   registered flags
//   wrt_count           conservative fill level, 0..2**ADDR_WIDTH
//   overflow            sticky: write attempted while full
module fifo_wrt_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH   = 120,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wrt_clk,
    input  logic                  wrt_rst_n,
    input  logic                  wrt_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH-1:0] wrt_addr,
    output logic [ADDR_WIDTH:0]   wrt_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wrt_count,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic          accept;
    logic [PW-1:0] rq_sync, rbin_s, full_cmp;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk     (wrt_clk),
        .rst_n   (wrt_rst_n),
        .d_async (rd_ptr_gray),
        .q_sync  (rq_sync)
    );

    // Full when our next pointer is one lap ahead of the synced read
    // pointer: in Gray that is the top two bits inverted, rest equal.
    generate
        if (PW > 2) begin : g_cmp
            assign full_cmp = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
        end else begin : g_cmp_small
            assign full_cmp = ~rq_sync;
        end
    endgenerate

    always_comb begin
        accept  = wrt_en & ~full_q;
        wbin_d  = wbin_q + PW'(accept);
        wgray_d = PW'(bin2gray(32'(wbin_d)));
        rbin_s  = PW'(gray2bin(32'(rq_sync)));
        full_d  = (wgray_d == full_cmp);
        // Synced read pointer lags, so this can only over-report.
        cnt_d   = wbin_d - rbin_s;
        af_d    = (32'(cnt_d) >= 32'(AF_THRESH));
        // A new overflow event beats a simultaneous clear.
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (wrt_en && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
        if (!wrt_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wrt_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wrt_ptr_gray = wgray_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign wrt_count    = cnt_q;
    assign overflow     = ovf_q;

endmodule
